// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the load-use hazard scoreboard.
package pipe_pkg;

    localparam logic [1:0] LOAD_NONE = 2'b00;
    localparam int         REG_ZERO  = 0;
    localparam int         LAT_MIN   = 1;
    localparam int         LAT_MAX   = 4;

    // Widest register address an entry can hold; narrower ids zero-extend.
    localparam int SB_DEST_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [SB_DEST_W-1:0] dest;
    } sbEntry_t;

    function automatic sbEntry_t mkEntry(input logic v,
                                         input logic [SB_DEST_W-1:0] d);
        sbEntry_t e;
        e.valid = v;
        e.dest  = d;
        return e;
    endfunction

endpackage

// File: rtl/load_sb_entry_match.sv
// One scoreboard entry compared against the ID-stage rs/rt operands.
module load_sb_entry_match
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  sbEntry_t           ent,
    input  logic [REG_AW-1:0]  rsId,
    input  logic [REG_AW-1:0]  rtId,
    input  logic               rsUsed,
    input  logic               rtUsed,
    output logic               hitRs,
    output logic               hitRt
);

    logic rsLive;
    logic rtLive;

    assign rsLive = rsUsed && (rsId != REG_AW'(REG_ZERO));
    assign rtLive = rtUsed && (rtId != REG_AW'(REG_ZERO));

    assign hitRs = rsLive && ent.valid && (ent.dest == SB_DEST_W'(rsId));
    assign hitRt = rtLive && ent.valid && (ent.dest == SB_DEST_W'(rtId));

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Multi-cycle load-use hazard unit; optional store-data forwarding
// relief is enabled with the LOAD_STORE_FWD_EN macro.
module load_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [1:0]        load_type_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              rs_used_id,
    input  logic              rt_used_id,
    input  logic              store_id,
    input  logic              mem_stall,
    input  logic              cnt_clr,
    output logic              keep_pc,
    output logic              keep_if_id,
    output logic              reset_id_ex,
    output logic              hold_mem,
    output logic [CNT_W-1:0]  stall_cnt
);

    sbEntry_t          ent [LOAD_LAT];
    logic [LOAD_LAT-1:0] hitRsV;
    logic [LOAD_LAT-1:0] hitRtV;
    logic              hitRs;
    logic              hitRt;
    logic              hazard;
    logic              stallCycle;
    logic              loadInEx;

    assign loadInEx = ex_valid
                   && (load_type_ex != LOAD_NONE)
                   && (rt_ex != REG_AW'(REG_ZERO));

    assign ent[0] = mkEntry(loadInEx, SB_DEST_W'(rt_ex));

    // Older loads keep advancing during a load-use bubble; only a
    // memory freeze holds them in place.
    generate
        if (LOAD_LAT > 1) begin : gStore
            sbEntry_t sbQ [1:LOAD_LAT-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 1; k < LOAD_LAT; k++) begin
                        sbQ[k] <= '0;
                    end
                end else if (!mem_stall) begin
                    sbQ[1] <= ent[0];
                    for (int k = 2; k < LOAD_LAT; k++) begin
                        sbQ[k] <= sbQ[k-1];
                    end
                end
            end

            for (genvar k = 1; k < LOAD_LAT; k++) begin : gTap
                assign ent[k] = sbQ[k];
            end
        end
    endgenerate

    generate
        for (genvar k = 0; k < LOAD_LAT; k++) begin : gMatch
            load_sb_entry_match #(
                .REG_AW (REG_AW)
            ) uMatch (
                .ent    (ent[k]),
                .rsId   (rs_id),
                .rtId   (rt_id),
                .rsUsed (rs_used_id),
                .rtUsed (rt_used_id),
                .hitRs  (hitRsV[k]),
                .hitRt  (hitRtV[k])
            );
        end
    endgenerate

    assign hitRs = |hitRsV;
    assign hitRt = |hitRtV;

`ifdef LOAD_STORE_FWD_EN
    // With single-cycle latency the only possible hit is entry 0, whose
    // data reaches the store in MEM through the MEM->MEM path.
    logic storeFwd;

    assign storeFwd = (LOAD_LAT == 1) && store_id && !hitRs;
    assign hazard   = hitRs || (hitRt && !storeFwd);
`else
    logic unusedStore;

    assign unusedStore = store_id;
    assign hazard      = hitRs || hitRt;
`endif

    assign stallCycle  = hazard && !mem_stall;

    assign keep_pc     = hazard || mem_stall;
    assign keep_if_id  = hazard || mem_stall;
    assign reset_id_ex = stallCycle;
    assign hold_mem    = mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stallCycle && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Directed bench: three scoreboard depths driven from one input set.
module tb_load_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid;
    logic [1:0] load_type_ex;
    logic [4:0] rt_ex;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       rs_used_id;
    logic       rt_used_id;
    logic       store_id;
    logic       mem_stall;
    logic       cnt_clr;

    logic        kp1, ki1, rie1, hm1;
    logic [1:0]  sc1;
    logic        kp2, ki2, rie2, hm2;
    logic [15:0] sc2;
    logic        kp3, ki3, rie3, hm3;
    logic [15:0] sc3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .load_type_ex(load_type_ex), .rt_ex(rt_ex),
        .rs_id(rs_id), .rt_id(rt_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .store_id(store_id), .mem_stall(mem_stall), .cnt_clr(cnt_clr),
        .keep_pc(kp1), .keep_if_id(ki1), .reset_id_ex(rie1),
        .hold_mem(hm1), .stall_cnt(sc1)
    );

    load_hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .load_type_ex(load_type_ex), .rt_ex(rt_ex),
        .rs_id(rs_id), .rt_id(rt_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .store_id(store_id), .mem_stall(mem_stall), .cnt_clr(cnt_clr),
        .keep_pc(kp2), .keep_if_id(ki2), .reset_id_ex(rie2),
        .hold_mem(hm2), .stall_cnt(sc2)
    );

    load_hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .load_type_ex(load_type_ex), .rt_ex(rt_ex),
        .rs_id(rs_id), .rt_id(rt_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .store_id(store_id), .mem_stall(mem_stall), .cnt_clr(cnt_clr),
        .keep_pc(kp3), .keep_if_id(ki3), .reset_id_ex(rie3),
        .hold_mem(hm3), .stall_cnt(sc3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setEx(input logic v, input logic [1:0] t,
                         input logic [4:0] r);
        ex_valid     = v;
        load_type_ex = t;
        rt_ex        = r;
    endtask

    task automatic setId(input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu,
                         input logic st);
        rs_id      = rs;
        rs_used_id = rsu;
        rt_id      = rt;
        rt_used_id = rtu;
        store_id   = st;
    endtask

    task automatic idle();
        setEx(1'b0, 2'b00, 5'd0);
        setId(5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        mem_stall = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic flushClr();
        idle();
        repeat (4) tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        chk("rst_cnt1", 32'(sc1), 32'd0);
        chk("rst_cnt3", 32'(sc3), 32'd0);
        chk("rst_kp2", 32'(kp2), 32'd0);
        chk("rst_hold", 32'(hm3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        flushClr();

        // lw $5 then dependent add, one edge per pipeline cycle
        setEx(1'b1, 2'b01, 5'd5);
        setId(5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        chk("l1_kp", 32'(kp1), 32'd1);
        chk("l1_kif", 32'(ki1), 32'd1);
        chk("l1_rie", 32'(rie1), 32'd1);
        chk("l1_hold", 32'(hm1), 32'd0);
        tick();
        setEx(1'b0, 2'b00, 5'd0);
        #1;
        chk("l1_release", 32'(kp1), 32'd0);
        chk("l1_cnt", 32'(sc1), 32'd1);
        chk("l3_c1", 32'(rie3), 32'd1);
        tick();
        #1;
        chk("l2_release", 32'(kp2), 32'd0);
        chk("l2_cnt", 32'(sc2), 32'd2);
        chk("l3_c2", 32'(rie3), 32'd1);
        tick();
        #1;
        chk("l3_release", 32'(kp3), 32'd0);
        chk("l3_cnt", 32'(sc3), 32'd3);
        flushClr();

        // independent reader, then dependent reader
        setEx(1'b1, 2'b01, 5'd7);
        setId(5'd8, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        chk("l3_indep", 32'(kp3), 32'd0);
        setId(5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        #1;
        chk("l3_dep_rt", 32'(kp3), 32'd1);
        flushClr();

        // zero register, unused operands, non-loads
        setEx(1'b1, 2'b01, 5'd0);
        setId(5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        #1;
        chk("zero_l1", 32'(kp1), 32'd0);
        chk("zero_l3", 32'(kp3), 32'd0);
        setEx(1'b1, 2'b10, 5'd4);
        setId(5'd3, 1'b1, 5'd4, 1'b0, 1'b0);
        #1;
        chk("rt_unused", 32'(kp1), 32'd0);
        rt_used_id = 1'b1;
        #1;
        chk("rt_used", 32'(kp1), 32'd1);
        ex_valid = 1'b0;
        #1;
        chk("ex_bubble", 32'(kp1), 32'd0);
        setEx(1'b1, 2'b00, 5'd4);
        #1;
        chk("not_load", 32'(kp1), 32'd0);
        flushClr();

        // freeze during a LOAD_LAT=2 stall
        setEx(1'b1, 2'b01, 5'd6);
        setId(5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        chk("frz_pre_rie", 32'(rie2), 32'd1);
        tick();
        setEx(1'b0, 2'b00, 5'd0);
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("frz_rie", 32'(rie2), 32'd0);
            chk("frz_kp", 32'(kp2), 32'd1);
            chk("frz_hold", 32'(hm2), 32'd1);
            tick();
        end
        mem_stall = 1'b0;
        #1;
        chk("frz_post_rie", 32'(rie2), 32'd1);
        chk("frz_cnt", 32'(sc2), 32'd1);
        tick();
        #1;
        chk("frz_done_kp", 32'(kp2), 32'd0);
        chk("frz_done_cnt", 32'(sc2), 32'd2);
        flushClr();

        // counter saturation on the 2-bit instance, clear beats increment
        setEx(1'b1, 2'b01, 5'd5);
        setId(5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        repeat (4) tick();
        #1;
        chk("sat_cnt", 32'(sc1), 32'd3);
        chk("sat_haz", 32'(rie1), 32'd1);
        chk("nosat_cnt", 32'(sc2), 32'd4);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        #1;
        chk("clr_prio", 32'(sc1), 32'd0);
        flushClr();

        // store data dependency
        setEx(1'b1, 2'b01, 5'd9);
        setId(5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        #1;
`ifdef LOAD_STORE_FWD_EN
        chk("st_rt_l1", 32'(kp1), 32'd0);
`else
        chk("st_rt_l1", 32'(kp1), 32'd1);
`endif
        chk("st_rt_l2", 32'(kp2), 32'd1);
        setId(5'd9, 1'b1, 5'd0, 1'b0, 1'b1);
        #1;
        chk("st_rs_l1", 32'(kp1), 32'd1);
        tick();
        setEx(1'b0, 2'b00, 5'd0);
        #1;
        chk("st_rs_once", 32'(kp1), 32'd0);
        flushClr();

        // asynchronous reset while a stall is pending
        setEx(1'b1, 2'b01, 5'd3);
        setId(5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        setEx(1'b0, 2'b00, 5'd0);
        #1;
        chk("ar_pre", 32'(kp3), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_kp3", 32'(kp3), 32'd0);
        chk("ar_kp2", 32'(kp2), 32'd0);
        chk("ar_cnt3", 32'(sc3), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
